calc_display_driver: RTL and testbench
======================================

CALC_DISPLAY_DRIVER -- requirements
Module: calc_display_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the number of clk cycles each display digit stays active.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Y, input, 14 bits: unsigned result magnitude from the calculator, 0..16383.
REQ-005 The block SHALL have port sinal, input, 1 bit: 1 marks a negative result.
REQ-006 The block SHALL have port EN, input, 1 bit: 1 means the calculator is on and the display is lit.
REQ-007 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-008 The block SHALL have port an, output, 6 bits: digit enables, active-low; an[0] is units, an[4] is ten-thousands, an[5] is sign.
REQ-009 The block SHALL have port busy, output, 1 bit: 1 while a conversion is in progress.
REQ-010 The block SHALL have port bcd, output, 20 bits: displayed value as 5 BCD digits, bcd[3:0] = units.
REQ-011 The block SHALL have port neg, output, 1 bit: displayed sign.

Function
REQ-012 The block SHALL implement FSM states IDLE and CONV.
REQ-013 In IDLE with EN=1, the block SHALL start a conversion when Y differs from the last captured Y, when sinal differs from the last captured sinal, or when the force flag is set.
REQ-014 On the start edge, the block SHALL snapshot Y and sinal, clear the force flag, set busy=1, and move to CONV.
REQ-015 CONV SHALL perform the 14 shift-add-3 (double-dabble) iterations, one per clk edge, on the snapshot.
REQ-016 On the 14th CONV edge, the block SHALL load bcd and neg from the result, set busy=0, and return to IDLE.
REQ-017 bcd SHALL therefore update at the 15th rising edge, counting the start edge as the 1st.
REQ-018 Changes on Y, sinal or EN during CONV SHALL NOT affect the running conversion; the IDLE comparison after it returns SHALL retrigger, at most 1 IDLE cycle between conversions.
REQ-019 A rising edge of EN SHALL set the force flag, so a conversion runs even if Y is unchanged.
REQ-020 While EN=0, the block SHALL drive an=6'h3F and seg=7'h7F within one clk, keep bcd/neg unchanged, and start no new conversion.
REQ-021 The refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count it SHALL wrap to 0 and the digit index SHALL advance 0,1,..,5 and wrap back to 0.
REQ-022 With EN=1, the block SHALL drive low exactly one an bit, selected by the digit index.
REQ-023 Digits 0-4 SHALL use active-low decimal patterns: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-024 Leading-zero blanking SHALL apply: digit k (1..4) shows seg=7F when bcd digits k..4 are all zero; digit 0 is always shown.
REQ-025 Digit 5 SHALL show seg=3F (minus) when neg=1 and a bcd digit is nonzero, and seg=7F otherwise.
REQ-026 The sign SHALL be suppressed on zero; "-0" is never shown.

Reset
REQ-027 While rst=1, the block SHALL immediately force seg=7F, an=3F, busy=0, bcd=0, neg=0, state=IDLE, refresh counter=0, digit index=0, last captured Y=0, last captured sinal=0, and force flag=1.
REQ-028 Reset asserted during CONV SHALL abort the conversion with no partial bcd update.
REQ-029 After rst is released with EN=1, the first conversion SHALL start on the first clk edge.

Verification
REQ-030 The bench SHALL cover: Y=16129, sinal=0, EN=1 from IDLE -> busy=1 for 14 cycles, then bcd=20'h16129, neg=0.
REQ-031 The bench SHALL cover: Y=5, sinal=1 -> bcd=20'h00005, neg=1; scan shows digit0 seg=12, digits1-4 seg=7F, digit5 seg=3F.
REQ-032 The bench SHALL cover: Y=100, then Y=200 during cycle 5 of CONV -> bcd=20'h00100 first, then a second conversion giving 20'h00200 with at most 1 IDLE cycle between them.
REQ-033 The bench SHALL cover: REFRESH_DIV=4, EN=1 -> an follows 3E,3D,3B,37,2F,1F,3E..., each held exactly 4 cycles.
REQ-034 The bench SHALL cover: EN 1->0 -> an=3F after the next edge; EN 0->1 with Y unchanged -> busy rises on the next edge and bcd is refreshed.
REQ-035 The bench SHALL cover: rst pulse at CONV iteration 7 -> all outputs take reset values asynchronously; after release, one full conversion of the current Y.

Source files
------------

// File: rtl/calc_display_driver.sv
// Calculator display driver: double-dabble binary-to-BCD conversion
// plus a 6-digit multiplexed 7-segment scan with blanking and sign.
//
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - asynchronous active-high reset
//   Y     - 14-bit unsigned result magnitude
//   sinal - 1 marks a negative result
//   EN    - 1 = calculator on, display lit
//   seg   - segments {g,f,e,d,c,b,a}, active-low
//   an    - digit enables, active-low (an[5] = sign)
//   busy  - conversion in progress
//   bcd   - displayed value, 5 BCD digits
//   neg   - displayed sign
module calc_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] Y,
    input  logic        sinal,
    input  logic        EN,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        busy,
    output logic [19:0] bcd,
    output logic        neg
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam int CW =
        (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [0:0]    state_q, state_d;
    logic [13:0]   yl_q, yl_d;
    logic          sl_q, sl_d;
    logic          force_q, force_d;
    logic          en_q;
    logic [33:0]   sh_q, sh_d;
    logic [3:0]    it_q, it_d;
    logic          sneg_q, sneg_d;
    logic          busy_q, busy_d;
    logic [19:0]   bcd_q, bcd_d;
    logic          neg_q, neg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;

    logic          en_rise;
    logic          start;
    logic [33:0]   dab;

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift.
    function automatic logic [33:0] dabble(input logic [33:0] s);
        logic [33:0] t;
        t = s;
        for (int k = 0; k < 5; k++) begin
            if (t[14+4*k +: 4] >= 4'd5)
                t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
        end
        return {t[32:0], 1'b0};
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h40;
            4'd1:    r = 7'h79;
            4'd2:    r = 7'h24;
            4'd3:    r = 7'h30;
            4'd4:    r = 7'h19;
            4'd5:    r = 7'h12;
            4'd6:    r = 7'h02;
            4'd7:    r = 7'h78;
            4'd8:    r = 7'h00;
            4'd9:    r = 7'h10;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    assign en_rise = EN & ~en_q;
    // The EN edge is folded in directly so the conversion starts on the
    // same edge that would otherwise only set the force flag.
    assign start = (state_q == IDLE) && EN &&
                   ((Y != yl_q) || (sinal != sl_q) ||
                    force_q || en_rise);
    assign dab = dabble(sh_q);

    always_comb begin
        state_d = state_q;
        yl_d    = yl_q;
        sl_d    = sl_q;
        force_d = force_q;
        sh_d    = sh_q;
        it_d    = it_q;
        sneg_d  = sneg_q;
        busy_d  = busy_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;

        if (en_rise)
            force_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = {20'd0, Y};
                    sneg_d  = sinal;
                    yl_d    = Y;
                    sl_d    = sinal;
                    force_d = 1'b0;
                    busy_d  = 1'b1;
                    it_d    = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_d = dab;
                it_d = it_q + 4'd1;
                if (it_q == 4'd13) begin
                    bcd_d   = dab[33:14];
                    neg_d   = sneg_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        dig_d = dig_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
            dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
        end
    end

    // Digit k is blanked when it and every more significant digit is 0.
    always_comb begin
        case (dig_q)
            3'd0: seg_d = dec7(bcd_q[3:0]);
            3'd1: seg_d = (bcd_q[19:4] == '0) ? 7'h7F
                                              : dec7(bcd_q[7:4]);
            3'd2: seg_d = (bcd_q[19:8] == '0) ? 7'h7F
                                              : dec7(bcd_q[11:8]);
            3'd3: seg_d = (bcd_q[19:12] == '0) ? 7'h7F
                                               : dec7(bcd_q[15:12]);
            3'd4: seg_d = (bcd_q[19:16] == '0) ? 7'h7F
                                               : dec7(bcd_q[19:16]);
            3'd5: seg_d = (neg_q && bcd_q != '0) ? 7'h3F : 7'h7F;
            default: seg_d = 7'h7F;
        endcase
        an_d = 6'h3F ^ (6'd1 << dig_q);
        if (!EN) begin
            seg_d = 7'h7F;
            an_d  = 6'h3F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            yl_q    <= '0;
            sl_q    <= 1'b0;
            force_q <= 1'b1;
            en_q    <= 1'b0;
            sh_q    <= '0;
            it_q    <= '0;
            sneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            dig_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 6'h3F;
        end else begin
            state_q <= state_d;
            yl_q    <= yl_d;
            sl_q    <= sl_d;
            force_q <= force_d;
            en_q    <= EN;
            sh_q    <= sh_d;
            it_q    <= it_d;
            sneg_q  <= sneg_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Directed bench for calc_display_driver with REFRESH_DIV = 4.
// Expected values are hand-computed constants.
module tb_calc_display_driver;

    logic        clk;
    logic        rst;
    logic [13:0] Y;
    logic        sinal;
    logic        EN;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        busy;
    logic [19:0] bcd;
    logic        neg;

    int nvec = 0;
    int nerr = 0;

    calc_display_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .Y     (Y),
        .sinal (sinal),
        .EN    (EN),
        .seg   (seg),
        .an    (an),
        .busy  (busy),
        .bcd   (bcd),
        .neg   (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run(input logic [13:0] y, input logic s,
                       input string tag);
        int n;
        Y = y;
        sinal = s;
        step();
        chk({tag, "_start"}, busy, 1);
        wait_done(n);
        chk({tag, "_len"}, n, 14);
    endtask

    task automatic scan(input logic [41:0] exp, input string tag);
        logic [5:0] tgt;
        for (int d = 0; d < 6; d++) begin
            tgt = 6'h3F ^ (6'd1 << d);
            for (int i = 0; i < 40 && an != tgt; i++)
                step();
            chk({tag, "_an"}, an, tgt);
            chk({tag, "_seg"}, seg, exp[d*7 +: 7]);
        end
    endtask

    logic [5:0] seq [7] = '{6'h3E, 6'h3D, 6'h3B, 6'h37,
                            6'h2F, 6'h1F, 6'h3E};

    initial begin
        int n;
        rst = 1'b1;
        EN = 1'b0;
        Y = '0;
        sinal = 1'b0;
        #1;
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 6'h3F);
        chk("rst_busy", busy, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_neg", neg, 0);

        // First conversion straight out of reset
        Y = 14'd16129;
        EN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("c1_busy1", busy, 1);
        for (int i = 2; i <= 14; i++) begin
            step();
            chk("c1_busy", busy, 1);
        end
        chk("c1_bcd_early", bcd, 0);
        step();
        chk("c1_done", busy, 0);
        chk("c1_bcd", bcd, 20'h16129);
        chk("c1_neg", neg, 0);

        // Small negative value, blanking and sign
        run(14'd5, 1'b1, "c2");
        chk("c2_bcd", bcd, 20'h00005);
        chk("c2_neg", neg, 1);
        scan({7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12}, "c2");

        // Scan order and dwell
        for (int i = 0; i < 40 && an != 6'h1F; i++) step();
        for (int i = 0; i < 40 && an != 6'h3E; i++) step();
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 4; k++) begin
                chk("scan_seq", an, seq[j]);
                step();
            end
        end

        // Y changes mid-conversion
        Y = 14'd100;
        sinal = 1'b0;
        step();
        chk("c3_start", busy, 1);
        repeat (4) step();
        Y = 14'd200;
        wait_done(n);
        chk("c3_len", n, 10);
        chk("c3_bcd", bcd, 20'h00100);
        chk("c3_neg", neg, 0);
        scan({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, "c3");
        for (int i = 0; i < 40 && busy; i++) step();
        chk("c3b_bcd", bcd, 20'h00200);

        // Back-to-back: at most one IDLE cycle
        Y = 14'd300;
        step();
        chk("c4_start", busy, 1);
        repeat (4) step();
        Y = 14'd400;
        wait_done(n);
        chk("c4_bcd", bcd, 20'h00300);
        step();
        chk("c4_retrig", busy, 1);
        wait_done(n);
        chk("c4_len", n, 14);
        chk("c4b_bcd", bcd, 20'h00400);

        // EN off then on with Y unchanged
        EN = 1'b0;
        step();
        chk("off_an", an, 6'h3F);
        chk("off_seg", seg, 7'h7F);
        repeat (3) step();
        chk("off_busy", busy, 0);
        chk("off_bcd", bcd, 20'h00400);
        EN = 1'b1;
        step();
        chk("on_busy", busy, 1);
        wait_done(n);
        chk("on_len", n, 14);
        chk("on_bcd", bcd, 20'h00400);

        // Reset during conversion
        Y = 14'd1234;
        step();
        chk("c5_start", busy, 1);
        repeat (6) step();
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_bcd", bcd, 0);
        chk("ar_neg", neg, 0);
        chk("ar_seg", seg, 7'h7F);
        chk("ar_an", an, 6'h3F);
        @(negedge clk);
        rst = 1'b0;
        run(14'd1234, 1'b0, "c5");
        chk("c5_bcd", bcd, 20'h01234);

        // Zero with sign: no "-0"
        run(14'd0, 1'b1, "c6");
        chk("c6_bcd", bcd, 0);
        chk("c6_neg", neg, 1);
        scan({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, "c6");

        // Maximum magnitude
        run(14'd16383, 1'b1, "c7");
        chk("c7_bcd", bcd, 20'h16383);
        scan({7'h3F, 7'h79, 7'h02, 7'h30, 7'h00, 7'h30}, "c7");

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
